// File: rtl/hazard3_irq_source_if.sv
// APB3 slave bus bundle for the hazard3_irq_source register block.
// Only the APB handshake/data signals are grouped; clock, reset and IRQ lines stay plain ports.
interface hazard3_irq_source_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/hazard3_irq_source.sv
// Peripheral-side IRQ generator: synchronises event strobes into sticky, maskable, registered IRQ levels.
// Optional event coalescing (per-line counters and timeout prescaler) under HAZARD3_IRQ_SOURCE_COALESCE_EN.
module hazard3_irq_source #(
    parameter int unsigned          NUM_LINES   = 8,
    parameter logic [NUM_LINES-1:0] SYNC_BYPASS = '0,
    parameter int unsigned          W_TIMEOUT   = 16
) (
    input  logic                 clk_always_on,
    input  logic                 rst_n,
    input  logic [NUM_LINES-1:0] event_in,
    hazard3_irq_source_if.slave  apb,
    output logic [NUM_LINES-1:0] irq
);

    typedef enum logic [1:0] {
        REG_PENDING  = 2'd0,
        REG_ENABLE   = 2'd1,
        REG_EDGE     = 2'd2,
        REG_COALESCE = 2'd3
    } reg_addr_e;

    reg_addr_e            addr;
    logic                 wr_en;
    logic [NUM_LINES-1:0] w1c;
    logic [NUM_LINES-1:0] ev_s, ev, set;
    logic [NUM_LINES-1:0] ev_meta_q, ev_meta_d, ev_sync_q, ev_sync_d, ev_d_q, ev_d_d;
    logic [NUM_LINES-1:0] pending_q, pending_d, enable_q, enable_d, edge_q, edge_d;
    logic [NUM_LINES-1:0] irq_q, irq_d;
    logic [31:0]          rdata;
    logic                 unused_bits;

    assign addr        = reg_addr_e'(apb.paddr[3:2]);
    assign wr_en       = apb.psel & apb.penable & apb.pwrite;
    assign w1c         = (wr_en && addr == REG_PENDING) ? apb.pwdata[NUM_LINES-1:0] : '0;
    assign unused_bits = ^{apb.paddr[1:0], apb.pwdata};

    always_comb begin
        ev_meta_d = event_in;
        ev_sync_d = ev_meta_q;
        ev_s      = (SYNC_BYPASS & event_in) | (~SYNC_BYPASS & ev_sync_q);
        ev_d_d    = ev_s;
        // Edge lines need a rising transition; level lines fire on every high cycle.
        ev        = ev_s & ~(edge_q & ev_d_q);
    end

`ifdef HAZARD3_IRQ_SOURCE_COALESCE_EN
    logic [7:0]           threshold_q, threshold_d, thr_eff;
    logic [W_TIMEOUT-1:0] timeout_q, timeout_d, presc_q, presc_d;
    logic [7:0]           cnt_q [NUM_LINES];
    logic [7:0]           cnt_d [NUM_LINES];
    logic [7:0]           cnt_base [NUM_LINES];
    logic                 coal_wr, tick;

    assign coal_wr = wr_en && addr == REG_COALESCE;
    assign thr_eff = (threshold_q == 8'd0) ? 8'd1 : threshold_q;
    assign tick    = (timeout_q != '0) && (presc_q == timeout_q - W_TIMEOUT'(1));

    always_comb begin
        threshold_d = threshold_q;
        timeout_d   = timeout_q;
        presc_d     = presc_q + W_TIMEOUT'(1);
        if (coal_wr) begin
            threshold_d = apb.pwdata[7:0];
            timeout_d   = apb.pwdata[16 +: W_TIMEOUT];
            presc_d     = '0;
        end else if (timeout_q == '0 || tick) begin
            presc_d = '0;
        end
        // A clear restarts the count from zero, so a same-cycle event counts as the first.
        for (int i = 0; i < NUM_LINES; i++) begin
            cnt_base[i] = w1c[i] ? 8'd0 : cnt_q[i];
            set[i]      = ({1'b0, cnt_base[i]} + 9'(ev[i]) >= {1'b0, thr_eff}) ||
                          (tick && cnt_base[i] != 8'd0);
            cnt_d[i]    = (ev[i] && cnt_base[i] != 8'hFF) ? cnt_base[i] + 8'd1 : cnt_base[i];
        end
    end

    always_ff @(posedge clk_always_on or negedge rst_n) begin
        if (!rst_n) begin
            threshold_q <= '0;
            timeout_q   <= '0;
            presc_q     <= '0;
            // NOTE: the counter array is small flop storage, not RAM, so it is reset with the rest of the state.
            for (int i = 0; i < NUM_LINES; i++) cnt_q[i] <= '0;
        end else begin
            threshold_q <= threshold_d;
            timeout_q   <= timeout_d;
            presc_q     <= presc_d;
            for (int i = 0; i < NUM_LINES; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    assign set = ev;
`endif

    always_comb begin
        // Set has priority over a same-cycle write-1-to-clear.
        pending_d = (pending_q & ~w1c) | set;
        enable_d  = (wr_en && addr == REG_ENABLE) ? apb.pwdata[NUM_LINES-1:0] : enable_q;
        edge_d    = (wr_en && addr == REG_EDGE)   ? apb.pwdata[NUM_LINES-1:0] : edge_q;
        irq_d     = pending_q & enable_q;
    end

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_always_on or negedge rst_n) begin
        if (!rst_n) begin
            ev_meta_q <= '0;
            ev_sync_q <= '0;
            ev_d_q    <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '1;
            irq_q     <= '0;
        end else begin
            ev_meta_q <= ev_meta_d;
            ev_sync_q <= ev_sync_d;
            ev_d_q    <= ev_d_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (apb.psel) begin
            case (addr)
                REG_PENDING: rdata[NUM_LINES-1:0] = pending_q;
                REG_ENABLE:  rdata[NUM_LINES-1:0] = enable_q;
                REG_EDGE:    rdata[NUM_LINES-1:0] = edge_q;
`ifdef HAZARD3_IRQ_SOURCE_COALESCE_EN
                REG_COALESCE: begin
                    rdata[7:0]            = threshold_q;
                    rdata[16 +: W_TIMEOUT] = timeout_q;
                end
`endif
                default: rdata = '0;
            endcase
        end
    end

    assign apb.prdata  = rdata;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = 1'b0;
    assign irq         = irq_q;

endmodule
